// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of C_NUM_REGS software-writable 32-bit control registers feeding Simulink user logic.
// Define OPB_REG_BANK_SHADOW_EN for shadow registers applied to the outputs by user_commit.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01098100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010981FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 8,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe,
  input  logic                      user_commit
);

  if ((C_OPB_AWIDTH != 32) || (C_OPB_DWIDTH != 32) || (C_NUM_REGS < 1) || (C_NUM_REGS > 64) ||
      (C_FAMILY == "") ||
      (({1'b0, C_HIGHADDR} - {1'b0, C_BASEADDR} + 33'd1) < 33'(4 * C_NUM_REGS))) begin : g_bad_cfg
    $error("opb_register_bank_ppc2simulink: unsupported parameter combination");
  end

  logic                  r_xfer_ack;
  logic [31:0]           r_dbus;
  logic [C_NUM_REGS-1:0] r_strobe;
  logic [31:0]           r_store [C_NUM_REGS];
  logic [31:0]           w_store_next [C_NUM_REGS];
  logic                  w_hit;
  logic [31:0]           w_offset;
  logic [29:0]           w_idx;
  logic [C_NUM_REGS-1:0] w_sel;
  logic [C_NUM_REGS-1:0] w_wr_sel;
  logic [31:0]           w_rd_data;
  logic                  w_unused;

  // Byte-lane merge: be[3] is OPB_BE[0] and covers the most-significant byte.
  function automatic logic [31:0] f_merge(input logic [31:0] cur, input logic [31:0] wdata,
                                          input logic [3:0] be);
    logic [31:0] v;
    v = cur;
    for (int b = 0; b < 4; b++) begin
      v[8*b +: 8] = be[b] ? wdata[8*b +: 8] : cur[8*b +: 8];
    end
    return v;
  endfunction

  // The pending ack masks the decode so a held select cannot re-trigger.
  assign w_hit    = OPB_select && !r_xfer_ack && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_offset = OPB_ABus - C_BASEADDR;
  assign w_idx    = w_offset[31:2];

  // Register decode, read mux and next-value computation.
  always_comb begin
    w_sel     = {C_NUM_REGS{1'b0}};
    w_wr_sel  = {C_NUM_REGS{1'b0}};
    w_rd_data = 32'd0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      w_sel[i]        = w_hit && (w_idx == 30'(i));
      w_wr_sel[i]     = w_sel[i] && !OPB_RNW;
      w_rd_data       = w_rd_data | (w_sel[i] ? r_store[i] : 32'd0);
      w_store_next[i] = w_wr_sel[i] ? f_merge(r_store[i], OPB_DBus, OPB_BE) : r_store[i];
    end
  end

  // Transfer acknowledge and registered read data (zero outside the ack cycle).
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_xfer_ack <= 1'b0;
      r_dbus     <= 32'd0;
    end else begin
      r_xfer_ack <= w_hit;
      r_dbus     <= (w_hit && OPB_RNW) ? w_rd_data : 32'd0;
    end
  end

  // Software-visible register storage.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) r_store[i] <= C_RESET_VAL;
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) r_store[i] <= w_store_next[i];
    end
  end

`ifdef OPB_REG_BANK_SHADOW_EN
  logic [31:0] r_out [C_NUM_REGS];

  // Commit copies every shadow (including a same-cycle write) to the outputs.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_strobe <= {C_NUM_REGS{1'b0}};
      for (int i = 0; i < C_NUM_REGS; i++) r_out[i] <= C_RESET_VAL;
    end else begin
      r_strobe <= user_commit ? {C_NUM_REGS{1'b1}} : {C_NUM_REGS{1'b0}};
      for (int i = 0; i < C_NUM_REGS; i++) r_out[i] <= user_commit ? w_store_next[i] : r_out[i];
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = r_out[g];
  end

  assign w_unused = &{1'b0, OPB_seqAddr, w_offset[1:0]};
`else
  // Write strobes pulse alongside the ack of a write to an implemented register.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_strobe <= {C_NUM_REGS{1'b0}};
    end else begin
      r_strobe <= w_wr_sel;
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = r_store[g];
  end

  assign w_unused = &{1'b0, OPB_seqAddr, user_commit, w_offset[1:0]};
`endif

  assign Sl_xferAck     = r_xfer_ack;
  assign Sl_DBus        = r_dbus;
  assign user_wr_strobe = r_strobe;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for opb_register_bank_ppc2simulink (default build): scoreboard of expected ack-cycle results.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01098100;
  localparam logic [31:0] HIGH = 32'h010981FF;
  localparam int          NREG = 8;

  typedef struct packed {
    logic [31:0]     dbus;
    logic [NREG-1:0] strobe;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:31]       abus;
  logic [0:3]        be;
  logic [0:31]       dbus_in;
  logic              rnw;
  logic              sel;
  logic              seq_addr;
  logic              commit;
  logic [0:31]       sl_dbus;
  logic              sl_err, sl_retry, sl_tout, sl_ack;
  logic [32*NREG-1:0] data_out;
  logic [NREG-1:0]   strobe;

  logic [31:0] model [NREG];
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_in),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr),
    .Sl_DBus(sl_dbus), .Sl_errAck(sl_err), .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .Sl_xferAck(sl_ack), .user_data_out(data_out), .user_wr_strobe(strobe), .user_commit(commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] packed_model();
    logic [255:0] p;
    p = 256'd0;
    for (int i = 0; i < NREG; i++) p[32*i +: 32] = model[i];
    return p;
  endfunction

  // One single-beat transfer, started just after a rising edge with the bus idle.
  task automatic do_xfer(input logic [31:0] addr, input logic [0:3] b_en, input logic [31:0] data,
                         input logic rd, input string tag);
    exp_t        e;
    logic [31:0] off;
    int          idx;
    logic        impl;
    off  = addr - BASE;
    idx  = int'(off >> 2);
    impl = (addr >= BASE) && (addr <= HIGH) && ((off >> 2) < NREG);
    e.dbus   = (rd && impl) ? model[idx] : 32'd0;
    e.strobe = (!rd && impl) ? NREG'(1 << idx) : {NREG{1'b0}};
    if (!rd && impl) begin
      for (int b = 0; b < 4; b++) begin
        if (b_en[b]) model[idx][31-8*b -: 8] = data[31-8*b -: 8];
      end
    end
    sb_q.push_back(e);
    abus = addr; be = b_en; dbus_in = data; rnw = rd; sel = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ack"}, sl_ack, 1'b1);
    e = sb_q.pop_front();
    chk({tag, "_dbus"}, sl_dbus, e.dbus);
    chk({tag, "_strobe"}, strobe, e.strobe);
    chk({tag, "_regs"}, data_out, packed_model());
    sel = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ack_low"}, sl_ack, 1'b0);
    chk({tag, "_dbus_zero"}, sl_dbus, 32'd0);
    chk({tag, "_strobe_low"}, strobe, {NREG{1'b0}});
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; abus = 32'd0; be = 4'b0000; dbus_in = 32'd0; rnw = 1'b0;
    sel = 1'b0; seq_addr = 1'b0; commit = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = 32'h00000000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", sl_ack, 1'b0);
    chk("rst_dbus", sl_dbus, 32'd0);
    chk("rst_strobe", strobe, {NREG{1'b0}});
    chk("rst_regs", data_out, packed_model());
    rst = 1'b0;
    @(posedge clk); #1;

    do_xfer(32'h01098104, 4'b1111, 32'hDEADBEEF, 1'b0, "wr1_full");
    do_xfer(32'h01098104, 4'b0100, 32'h11333344, 1'b0, "wr1_lane1");
    do_xfer(32'h01098104, 4'b0000, 32'h00000000, 1'b1, "rd1");
    do_xfer(32'h0109810C, 4'b1001, 32'hA1B2C3D4, 1'b0, "wr3_lanes03");
    do_xfer(32'h01098117, 4'b0000, 32'hFFFFFFFF, 1'b0, "wr5_be0");
    do_xfer(32'h0109811C, 4'b0011, 32'h01020304, 1'b0, "wr7_lanes23");
    do_xfer(32'h0109810E, 4'b0000, 32'h00000000, 1'b1, "rd3_be0");
    do_xfer(32'h01098180, 4'b1111, 32'h00000005, 1'b0, "wr_idx32");
    do_xfer(32'h01098180, 4'b1111, 32'h00000000, 1'b1, "rd_idx32");
    do_xfer(32'h010981FC, 4'b1111, 32'h00000000, 1'b1, "rd_last");

    // Select held on one address: ack only every second cycle.
    e.dbus = model[1]; e.strobe = {NREG{1'b0}};
    sb_q.push_back(e);
    sb_q.push_back(e);
    abus = 32'h01098104; be = 4'b1111; rnw = 1'b1; sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("hold_ack%0d", k), sl_ack, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k % 2 == 1) begin
        e = sb_q.pop_front();
        chk($sformatf("hold_dbus%0d", k), sl_dbus, e.dbus);
      end else begin
        chk($sformatf("hold_dbus%0d", k), sl_dbus, 32'd0);
      end
    end
    sel = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_ack", sl_ack, 1'b0);

    // Addresses just outside the decoded window.
    abus = 32'h01098200; rnw = 1'b1; sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("above_ack%0d", k), sl_ack, 1'b0);
      chk($sformatf("above_dbus%0d", k), sl_dbus, 32'd0);
    end
    abus = 32'h010980FC; rnw = 1'b0; dbus_in = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("below_ack%0d", k), sl_ack, 1'b0);
    end
    chk("below_regs", data_out, packed_model());
    sel = 1'b0;
    @(posedge clk); #1;

    // Reset arriving with a write in flight: dropped, no ack, registers cleared.
    rst = 1'b1; abus = 32'h01098108; be = 4'b1111; dbus_in = 32'hFFFFFFFF; rnw = 1'b0; sel = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = 32'h00000000;
    @(posedge clk); #1;
    chk("midrst_ack", sl_ack, 1'b0);
    chk("midrst_strobe", strobe, {NREG{1'b0}});
    chk("midrst_regs", data_out, packed_model());
    rst = 1'b0; sel = 1'b0;
    @(posedge clk); #1;
    chk("midrst_after_ack", sl_ack, 1'b0);
    do_xfer(32'h01098104, 4'b1111, 32'h00000000, 1'b1, "rd1_after_rst");

    chk("sb_empty", 256'(sb_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
